serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
- Bit-serial N-bit subtractor built around a 1-bit subtract cell plus a borrow flip-flop.
- Processes one bit per clock, LSB first, and computes diff = a - b - bin.
- Sits directly downstream of the operand source. It sequences operand bits into the combinational half/full-subtract stage and collects the difference and borrow.
- Valid/ready handshake on both the input and the output side.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit counter width; derived, never overridden.

Ports:
- clk, input, 1, single clock; all flops on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands present.
- in_ready, output, 1, block can accept operands.
- a, input, WIDTH, minuend.
- b, input, WIDTH, subtrahend.
- bin, input, 1, borrow-in.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer takes the result.
- diff, output, WIDTH, (a - b - bin) mod 2^WIDTH.
- bout, output, 1, final borrow; 1 iff a < b + bin, unsigned.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - diff=0, bout=0, out_valid=0, in_ready=1.
  - Internal shift registers and counter = 0.
  - Reset mid-RUN or mid-DONE aborts the operation; no partial result is ever presented.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at an edge: latch a, b into shift regs, load borrow FF with bin, clear diff shift reg, count=0, go to RUN.
- RUN:
  - in_ready=0; in_valid and operand inputs are ignored.
  - Each edge uses a_i = a_sh[0], b_i = b_sh[0], br = borrow FF:
    - d_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d_i shifts into the MSB of the diff shift reg (right shift); a_sh and b_sh shift right; count increments.
  - On the edge where count reaches WIDTH-1 (the WIDTH-th bit): go to DONE.
- DONE:
  - out_valid=1.
  - diff = diff shift reg; bout = borrow FF.
  - Outputs are held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE, out_valid=0.
  - diff and bout keep their last value until the next DONE.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles minimum.
- No bypass:
  - in_ready is 0 during the handshake cycle in DONE.
  - in_ready returns to 1 the cycle after the output handshake.
- out_valid never deasserts without out_ready (AXI-style hold).
- Boundaries:
  - a=b with bin=0 → diff=0, bout=0.
  - a=b with bin=1 → diff = all ones, bout=1.
  - 0 - (2^WIDTH-1) → diff=1, bout=1.
  - Counter wrap is not possible; count is cleared on every accept.

Optional Feature:
- Macro: SERIAL_SUB_CMP_EN.
- Defined:
  - Adds outputs lt, eq, gt (1 bit each): unsigned comparison of a vs b, ignoring bin. Valid whenever out_valid=1; reset value 0.
  - Computed serially alongside the subtract:
    - eq_r is set to 1 on accept and cleared on any bit where a_i != b_i.
    - On any differing bit, lt_r <= b_i. The last (most significant) difference wins.
    - gt = ~eq & ~lt.
  - Exactly one of lt/eq/gt is 1 in DONE.
- Undefined: these ports and their logic do not exist; the port list is exactly as above.

Test Plan (WIDTH=8):
- a=0x5A, b=0x33, bin=0:
  - out_valid rises 8 edges after accept.
  - diff=0x27, bout=0.
- a=0x10, b=0x20, bin=0 → diff=0xF0, bout=1. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- Backpressure:
  - Complete 0x80-0x01 with out_ready held 0 for 5 cycles.
  - diff=0x7F and bout=0 stay stable; out_valid stays 1; in_ready stays 0.
  - A second in_valid pulse presented meanwhile is not accepted.
  - in_ready=1 the cycle after out_ready is asserted.
- Reset mid-operation:
  - Assert rst_n=0 four edges into RUN.
  - out_valid=0, diff=0x00, bout=0, in_ready=1 immediately (asynchronous).
  - After release, a fresh 0xFF-0x0F yields diff=0xF0, bout=0.
- Back-to-back: three operations with out_ready tied 1 → each result appears in order, with exactly 10-cycle spacing between accepts.
- SERIAL_SUB_CMP_EN:
  - a=0x80, b=0x7F → gt=1, lt=0, eq=0.
  - a=0x3C, b=0x3C → eq=1.
  - a=0x01, b=0x02 → lt=1.

Source files
------------

// File: rtl/serial_sub.sv
// serial_sub -- bit-serial N-bit subtractor, diff = a - b - bin.
//
// A 1-bit full-subtract cell plus a borrow flip-flop process one operand bit
// per clock, LSB first. Operands are latched into shift registers on the
// input handshake. The result is presented in DONE until the consumer takes
// it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload until that edge. This block
// never drops out_valid, and never changes diff/bout, until out_ready has been
// seen. in_ready is high only in IDLE, so there is no input/output bypass.
//
// Optional feature: define SERIAL_SUB_CMP_EN to add the lt/eq/gt outputs. They
// give an unsigned comparison of a vs b, ignoring bin, and are built serially
// alongside the subtract.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake (a, b, bin)
//   out_valid, out_ready result handshake (diff, bout [, lt, eq, gt])
//   diff                (a - b - bin) mod 2^WIDTH
//   bout                final borrow, 1 iff a < b + bin (unsigned)
module serial_sub #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_CMP_EN
  output logic             lt,
  output logic             eq,
  output logic             gt,
`endif
  output logic             bout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;

  // One-bit subtract cell
  logic             a_i;
  logic             b_i;
  logic             d_i;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] d_sh_next;

  always_comb begin
    a_i       = a_sh[0];
    b_i       = b_sh[0];
    d_i       = a_i ^ b_i ^ br;
    br_next   = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    last_bit  = (cnt == CNT_W'(WIDTH - 1));
    d_sh_next = {d_i, d_sh[WIDTH-1:1]};
  end

`ifdef SERIAL_SUB_CMP_EN
  logic eq_r;
  logic lt_r;
  logic lt_next;
  logic eq_next;

  // Bits are visited LSB first, so the last differing bit seen is the most
  // significant one and decides the ordering.
  always_comb begin
    lt_next = (a_i != b_i) ? b_i : lt_r;
    eq_next = eq_r & (a_i == b_i);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      d_sh      <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef SERIAL_SUB_CMP_EN
      eq_r      <= 1'b0;
      lt_r      <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            br       <= bin;
            d_sh     <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
`ifdef SERIAL_SUB_CMP_EN
            eq_r     <= 1'b1;
            lt_r     <= 1'b0;
`endif
          end
        end

        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_sh_next;
          br   <= br_next;
          cnt  <= cnt + CNT_W'(1);
`ifdef SERIAL_SUB_CMP_EN
          eq_r <= eq_next;
          lt_r <= lt_next;
`endif
          // Result registers load only on the final bit. A reset taken
          // mid-RUN therefore can never leave a partial result visible.
          if (last_bit) begin
            diff      <= d_sh_next;
            bout      <= br_next;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SERIAL_SUB_CMP_EN
            lt        <= lt_next;
            eq        <= eq_next;
            gt        <= ~lt_next & ~eq_next;
`endif
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub -- self-checking bench for serial_sub (WIDTH=8).
// Table-driven vectors plus hand-written sequences for backpressure, reset
// mid-operation and back-to-back throughput. Expected results go into exp_q
// when the stimulus is driven and are popped when the DUT hands a result over.
module tb_serial_sub;
  localparam int WIDTH = 8;
  localparam int EW    = WIDTH + 4;  // {diff, bout, lt, eq, gt}

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_CMP_EN
  logic             lt;
  logic             eq;
  logic             gt;
`endif

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SERIAL_SUB_CMP_EN
    .lt        (lt),
    .eq        (eq),
    .gt        (gt),
`endif
    .bout      (bout)
  );

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: widened unsigned subtraction, borrow is the extra bit.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] ma,
                                          input logic [WIDTH-1:0] mb,
                                          input logic mbin);
    logic [WIDTH:0] r;
    r = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
    return {r[WIDTH-1:0], r[WIDTH], ma < mb, ma == mb, ma > mb};
  endfunction

  // Monitor: samples on the falling edge, the handshake completes on the next rise.
  logic prev_ov = 1'b0;
  logic prev_or = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int acc;
    if (!rst_n) begin
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      if (prev_ov && !prev_or) check("out_valid_hold", out_valid, 1);
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) fail_now("out_valid_without_accept");
        else begin
          acc = lat_q.pop_front();
          check("latency", cyc - acc, WIDTH);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else begin
          e = exp_q.pop_front();
          check("diff", diff, e[EW-1:4]);
          check("bout", bout, e[3]);
`ifdef SERIAL_SUB_CMP_EN
          check("lt", lt, e[2]);
          check("eq", eq, e[1]);
          check("gt", gt, e[0]);
`endif
        end
      end
      if (in_valid && in_ready) lat_q.push_back(cyc + 1);
      prev_ov = out_valid;
      prev_or = out_ready;
    end
  end

  // Driver tasks: called and returning at posedge+#1.
  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic tbin, input logic [EW-1:0] e, output int acc_edge);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      fail_now("in_ready_timeout");
      acc_edge = -1;
      return;
    end
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    acc_edge = cyc;
    in_valid = 1'b0;
    // Scramble operand inputs; RUN must ignore them.
    a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || out_valid) begin
      fail_now("drain_timeout");
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             lt;
    logic             eq;
    logic             gt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int acc;
    int acc3[3];
    int n;
    logic [WIDTH-1:0] ra, rb;
    logic rbin;

    //               a      b      bin   diff   bout  lt    eq    gt
    vecs[0] = {8'h5A, 8'h33, 1'b0, 8'h27, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = {8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = {8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = {8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = {8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = {8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = {8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = {8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin,
            {vecs[i].d, vecs[i].bo, vecs[i].lt, vecs[i].eq, vecs[i].gt}, acc);
      drain();
    end

    // Backpressure: 0x80 - 0x01 held for 5 cycles, stray in_valid ignored
    out_ready = 1'b0;
    do_op(8'h80, 8'h01, 1'b0, {8'h7F, 1'b0, 1'b0, 1'b0, 1'b1}, acc);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) fail_now("bp_out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a = 8'h44; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
      end
      if (i == 3) in_valid = 1'b0;
      @(negedge clk);
      check("bp_diff", diff, 8'h7F);
      check("bp_bout", bout, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", in_ready, 1);
    check("bp_out_valid_after", out_valid, 0);
    repeat (12) @(posedge clk);
    #1;
    check("bp_no_stray_op", {31'd0, out_valid} + exp_q.size(), 0);

    // Reset mid-RUN
    do_op(8'h12, 8'h34, 1'b1, model(8'h12, 8'h34, 1'b1), acc);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_bout", bout, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("mid_rst_no_result", out_valid, 0);
    do_op(8'hFF, 8'h0F, 1'b0, {8'hF0, 1'b0, 1'b0, 1'b0, 1'b1}, acc);
    drain();

    // Back-to-back with out_ready tied high
    for (int i = 0; i < 3; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbin = 1'($urandom_range(0, 1));
      do_op(ra, rb, rbin, model(ra, rb, rbin), acc3[i]);
    end
    check("b2b_spacing_1", acc3[1] - acc3[0], WIDTH + 2);
    check("b2b_spacing_2", acc3[2] - acc3[1], WIDTH + 2);
    drain();

    // Random operations with random output stalls
    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbin = 1'($urandom_range(0, 1));
      if (i % 5 == 0) rb = ra;
      do_op(ra, rb, rbin, model(ra, rb, rbin), acc);
      out_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(6, 14)) @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
